// File: rtl/wired_commit.sv
// wired_commit: two-wide in-order ROB commit with exception/redirect drain of the backend.
// Latency: retire and store-commit strobes are combinational; redirect appears one cycle after the event.
// Backpressure: a slot0 store waits for sb_commit_ready_i; dispatch is held off via flush_o while draining.
module wired_commit #(
  parameter int ROB_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [1:0][ROB_LEN-1:0] c_rrrid_o,
  input  logic [1:0]              c_rob_valid_i,
  input  logic [1:0]              c_excp_i,
  input  logic [1:0]              c_need_jump_i,
  input  logic [1:0][31:0]        c_jump_target_i,
  input  logic [1:0]              c_store_i,
  input  logic [ROB_LEN-1:0]      rob_tail_i,
  input  logic [31:0]             excp_entry_i,
  output logic [1:0]              c_retire_o,
  output logic                    sb_commit_valid_o,
  input  logic                    sb_commit_ready_i,
  output logic                    redirect_valid_o,
  output logic [31:0]             redirect_pc_o,
  output logic                    flush_o
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ROB_LEN-1:0] head_q, head_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [ROB_LEN-1:0] remaining;
  logic [1:0]         retire;
  logic               sb_vld;

  // Entries still allocated behind head; only meaningful while draining (dispatch stalled).
  assign remaining = rob_tail_i - head_q;

  assign c_rrrid_o[0] = head_q;
  assign c_rrrid_o[1] = head_q + ROB_LEN'(1);

  // Combinational strobes are forced low while reset is held so reset takes effect immediately.
  assign c_retire_o        = rst ? 2'b00 : retire;
  assign sb_commit_valid_o = rst ? 1'b0 : sb_vld;
  assign redirect_valid_o  = redirect_valid_q;
  assign redirect_pc_o     = redirect_pc_q;
  assign flush_o           = (state_q == DRAIN);

  // Next-state: retire decision, redirect capture and RUN/DRAIN transitions.
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    retire           = 2'b00;
    sb_vld           = 1'b0;
    case (state_q)
      RUN: begin
        sb_vld    = c_rob_valid_i[0] & c_store_i[0];
        retire[0] = c_rob_valid_i[0] & (~c_store_i[0] | sb_commit_ready_i);
        retire[1] = retire[0] & c_rob_valid_i[1] & ~c_excp_i[0] & ~c_need_jump_i[0] & ~c_store_i[1];
        // Lowest retiring slot with an exception or jump wins; exception beats jump.
        if (retire[0] && (c_excp_i[0] || c_need_jump_i[0])) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = c_excp_i[0] ? excp_entry_i : c_jump_target_i[0];
          state_d          = DRAIN;
        end else if (retire[1] && (c_excp_i[1] || c_need_jump_i[1])) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = c_excp_i[1] ? excp_entry_i : c_jump_target_i[1];
          state_d          = DRAIN;
        end
      end
      DRAIN: begin
        // Retire unconditionally to unwind rename state; leave once the last entries go.
        if (remaining >= ROB_LEN'(2)) begin
          retire = 2'b11;
        end else if (remaining == ROB_LEN'(1)) begin
          retire = 2'b01;
        end
        if (remaining <= ROB_LEN'(2)) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    head_d = head_q + ROB_LEN'(retire[0]) + ROB_LEN'(retire[1]);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= RUN;
      head_q           <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      head_q           <= head_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_wired_commit.sv
// Testbench for wired_commit: behavioural model plus directed and randomized stimulus.
module tb_wired_commit;
  localparam int ROB_LEN = 5;
  localparam int N = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [1:0][ROB_LEN-1:0] c_rrrid_o;
  logic [1:0]              c_rob_valid_i;
  logic [1:0]              c_excp_i;
  logic [1:0]              c_need_jump_i;
  logic [1:0][31:0]        c_jump_target_i;
  logic [1:0]              c_store_i;
  logic [ROB_LEN-1:0]      rob_tail_i;
  logic [31:0]             excp_entry_i;
  logic [1:0]              c_retire_o;
  logic                    sb_commit_valid_o;
  logic                    sb_commit_ready_i;
  logic                    redirect_valid_o;
  logic [31:0]             redirect_pc_o;
  logic                    flush_o;

  wired_commit #(.ROB_LEN(ROB_LEN)) dut (
    .clk(clk), .rst(rst),
    .c_rrrid_o(c_rrrid_o),
    .c_rob_valid_i(c_rob_valid_i),
    .c_excp_i(c_excp_i),
    .c_need_jump_i(c_need_jump_i),
    .c_jump_target_i(c_jump_target_i),
    .c_store_i(c_store_i),
    .rob_tail_i(rob_tail_i),
    .excp_entry_i(excp_entry_i),
    .c_retire_o(c_retire_o),
    .sb_commit_valid_o(sb_commit_valid_o),
    .sb_commit_ready_i(sb_commit_ready_i),
    .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o),
    .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: ROB head, whether a drain is in progress, pending redirect.
  int       m_head;
  bit       m_drain;
  bit       m_rv;
  int unsigned m_rpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    c_rob_valid_i     = 2'b00;
    c_excp_i          = 2'b00;
    c_need_jump_i     = 2'b00;
    c_store_i         = 2'b00;
    sb_commit_ready_i = 1'b0;
    c_jump_target_i[0] = 32'h0;
    c_jump_target_i[1] = 32'h0;
    rob_tail_i        = ROB_LEN'(m_head);
  endtask

  task automatic model_reset();
    m_head = 0; m_drain = 0; m_rv = 0; m_rpc = 0;
  endtask

  // Move from posedge+1 to the middle of the cycle.
  task automatic mid();
    #3;
  endtask

  // Compare all outputs against the model, advance the model, move to next posedge+1.
  task automatic adv();
    int n, rem;
    bit ev, done;
    int unsigned evpc;
    logic [1:0] exp_ret;
    bit exp_sb;
    n = 0; ev = 0; evpc = 0; done = 0; exp_sb = 0;
    if (!m_drain) begin
      exp_sb = c_rob_valid_i[0] && c_store_i[0];
      if (c_rob_valid_i[0] && (!c_store_i[0] || sb_commit_ready_i)) n = 1;
      if (n == 1 && c_rob_valid_i[1] && !c_excp_i[0] && !c_need_jump_i[0] && !c_store_i[1]) n = 2;
      for (int i = 0; i < n; i++) begin
        if (!ev && (c_excp_i[i] || c_need_jump_i[i])) begin
          ev = 1;
          evpc = c_excp_i[i] ? excp_entry_i : c_jump_target_i[i];
        end
      end
    end else begin
      rem = (int'(rob_tail_i) - m_head + N) % N;
      n = (rem < 2) ? rem : 2;
      done = (rem <= 2);
    end
    exp_ret = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    chk("rrrid0", 32'(c_rrrid_o[0]), 32'(m_head));
    chk("rrrid1", 32'(c_rrrid_o[1]), 32'((m_head + 1) % N));
    chk("retire", 32'(c_retire_o), 32'(exp_ret));
    chk("sb_valid", 32'(sb_commit_valid_o), 32'(exp_sb));
    chk("flush", 32'(flush_o), 32'(m_drain));
    chk("redirect_valid", 32'(redirect_valid_o), 32'(m_rv));
    if (m_rv) chk("redirect_pc", redirect_pc_o, m_rpc);
    m_head = (m_head + n) % N;
    m_rv = ev;
    if (ev) m_rpc = evpc;
    m_drain = m_drain ? !done : ev;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    mid();
    adv();
  endtask

  // Retire one plain entry per cycle until the model head reaches h (RUN only).
  task automatic goto_head(input int h);
    int guard;
    guard = 0;
    while (m_head != h && guard < 64) begin
      idle();
      c_rob_valid_i = 2'b01;
      cyc();
      guard++;
    end
    chk("goto_head", 32'(m_head), 32'(h));
  endtask

  initial begin
    model_reset();
    idle();
    excp_entry_i = 32'h1c008000;
    rst = 1'b1;
    // Inputs that would retire in RUN: outputs must still be low under reset.
    c_rob_valid_i = 2'b11;
    c_store_i = 2'b01;
    sb_commit_ready_i = 1'b1;
    #2;
    chk("rst_retire", 32'(c_retire_o), 32'h0);
    chk("rst_sb", 32'(sb_commit_valid_o), 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_rv", 32'(redirect_valid_o), 32'h0);
    chk("rst_rpc", redirect_pc_o, 32'h0);
    chk("rst_head", 32'(c_rrrid_o[0]), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // Two ALU entries from head=3.
    goto_head(3);
    idle(); c_rob_valid_i = 2'b11;
    mid();
    chk("alu_retire11", 32'(c_retire_o), 32'h3);
    adv();
    idle(); mid();
    chk("alu_head5", 32'(c_rrrid_o[0]), 32'd5);
    chk("alu_no_redirect", 32'(redirect_valid_o), 32'h0);
    adv();

    // Wrap at head=31.
    goto_head(31);
    idle(); c_rob_valid_i = 2'b11;
    mid();
    chk("wrap_id0", 32'(c_rrrid_o[0]), 32'd31);
    chk("wrap_id1", 32'(c_rrrid_o[1]), 32'd0);
    adv();
    idle(); mid();
    chk("wrap_head1", 32'(c_rrrid_o[0]), 32'd1);
    adv();

    // Store backpressure: two stalled cycles, then a single handshake.
    for (int k = 0; k < 3; k++) begin
      idle();
      c_rob_valid_i = 2'b11;
      c_store_i = 2'b11;
      sb_commit_ready_i = (k == 2);
      mid();
      chk("st_retire", 32'(c_retire_o), (k == 2) ? 32'h1 : 32'h0);
      chk("st_sb_valid", 32'(sb_commit_valid_o), 32'h1);
      adv();
    end

    // Jump at head=4, tail=10: drain 2,2,1.
    goto_head(4);
    idle();
    c_rob_valid_i = 2'b11; c_need_jump_i = 2'b01;
    c_jump_target_i[0] = 32'h1c000100; rob_tail_i = 5'd10;
    mid();
    chk("jmp_retire01", 32'(c_retire_o), 32'h1);
    adv();
    idle(); rob_tail_i = 5'd10; mid();
    chk("jmp_rv", 32'(redirect_valid_o), 32'h1);
    chk("jmp_rpc", redirect_pc_o, 32'h1c000100);
    chk("jmp_flush", 32'(flush_o), 32'h1);
    chk("drain1", 32'(c_retire_o), 32'h3);
    adv();
    idle(); rob_tail_i = 5'd10; mid();
    chk("drain2", 32'(c_retire_o), 32'h3);
    chk("drain2_rv", 32'(redirect_valid_o), 32'h0);
    adv();
    idle(); rob_tail_i = 5'd10; mid();
    chk("drain3", 32'(c_retire_o), 32'h1);
    adv();
    idle(); rob_tail_i = 5'd10; mid();
    chk("drain_done_flush", 32'(flush_o), 32'h0);
    chk("drain_done_head", 32'(c_rrrid_o[0]), 32'd10);
    adv();

    // Slot1 exception with nothing behind it.
    idle();
    c_rob_valid_i = 2'b11; c_excp_i = 2'b10;
    rob_tail_i = ROB_LEN'((m_head + 2) % N);
    mid();
    chk("exc_retire11", 32'(c_retire_o), 32'h3);
    adv();
    idle(); rob_tail_i = ROB_LEN'(m_head); mid();
    chk("exc_rpc", redirect_pc_o, 32'h1c008000);
    chk("exc_flush", 32'(flush_o), 32'h1);
    chk("exc_noretire", 32'(c_retire_o), 32'h0);
    adv();
    idle(); mid();
    chk("exc_flush_off", 32'(flush_o), 32'h0);
    adv();

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      if (!m_drain) rob_tail_i = ROB_LEN'((m_head + $urandom_range(0, 9)) % N);
      c_rob_valid_i[0] = ($urandom_range(0, 3) != 0);
      c_rob_valid_i[1] = ($urandom_range(0, 3) != 0);
      c_excp_i[0] = ($urandom_range(0, 9) == 0);
      c_excp_i[1] = ($urandom_range(0, 9) == 0);
      c_need_jump_i[0] = ($urandom_range(0, 7) == 0);
      c_need_jump_i[1] = ($urandom_range(0, 7) == 0);
      c_store_i[0] = ($urandom_range(0, 2) == 0);
      c_store_i[1] = ($urandom_range(0, 2) == 0);
      sb_commit_ready_i = $urandom_range(0, 1);
      c_jump_target_i[0] = $urandom;
      c_jump_target_i[1] = $urandom;
      excp_entry_i = $urandom;
      cyc();
    end

    // Reset in the middle of a long drain.
    while (m_drain) begin
      idle(); cyc();
    end
    idle();
    c_rob_valid_i = 2'b01; c_excp_i = 2'b01;
    rob_tail_i = ROB_LEN'((m_head + 20) % N);
    cyc();
    chk("pre_rst_drain", 32'(flush_o), 32'h1);
    c_rob_valid_i = 2'b11;
    c_store_i = 2'b01;
    #1 rst = 1'b1;
    #1;
    chk("mrst_retire", 32'(c_retire_o), 32'h0);
    chk("mrst_flush", 32'(flush_o), 32'h0);
    chk("mrst_rv", 32'(redirect_valid_o), 32'h0);
    chk("mrst_rpc", redirect_pc_o, 32'h0);
    chk("mrst_sb", 32'(sb_commit_valid_o), 32'h0);
    chk("mrst_head", 32'(c_rrrid_o[0]), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle();
    c_rob_valid_i = 2'b11;
    mid();
    chk("post_rst_retire", 32'(c_retire_o), 32'h3);
    adv();
    for (int k = 0; k < 5; k++) begin
      idle(); c_rob_valid_i = 2'b01; cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wired_commit.md
WIRED_COMMIT -- requirements
Module: wired_commit

Interface
REQ-001 Parameter ROB_LEN, default 5; ROB depth = 2^ROB_LEN entries.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 c_rrrid_o  out  2xROB_LEN  ROB ids read this cycle: [0]=head, [1]=head+1.
REQ-005 c_rob_valid_i  in  2  entry at c_rrrid_o[i] is allocated and written back.
REQ-006 c_excp_i  in  2  entry raised an exception.
REQ-007 c_need_jump_i  in  2  entry requires a redirect.
REQ-008 c_jump_target_i  in  2x32  redirect target per entry.
REQ-009 c_store_i  in  2  entry holds a pending store-buffer write.
REQ-010 rob_tail_i  in  ROB_LEN  next ROB id dispatch will allocate.
REQ-011 excp_entry_i  in  32  exception handler PC.
REQ-012 c_retire_o  out  2  retire strobes to ROB/rename; c_retire_o[1] implies c_retire_o[0].
REQ-013 sb_commit_valid_o / sb_commit_ready_i  out/in  1/1  store-buffer commit handshake.
REQ-014 redirect_valid_o / redirect_pc_o  out/out  1/32  frontend redirect.
REQ-015 flush_o  out  1  backend flush in progress; dispatch is stalled while high.

Function
REQ-016 State: head (ROB_LEN bits), FSM {RUN, DRAIN}, registered redirect_valid_o/redirect_pc_o.
REQ-017 c_rrrid_o[1] = head+1 mod 2^ROB_LEN; wrap from 2^ROB_LEN-1 to 0 is required.
REQ-018 RUN, slot0 retires iff c_rob_valid_i[0] and (!c_store_i[0] or sb_commit_ready_i).
REQ-019 RUN, slot1 retires iff slot0 retires, c_rob_valid_i[1], !c_excp_i[0], !c_need_jump_i[0], and !c_store_i[1].
  - Consequence: at most one store commits per cycle.
REQ-020 sb_commit_valid_o = RUN and c_rob_valid_i[0] and c_store_i[0], combinational.
  - A store is committed exactly in cycles where valid and ready are both high.
REQ-021 c_retire_o is combinational from the current-cycle inputs and state.
  - head advances by popcount(c_retire_o) at the edge.
REQ-022 Event: a retiring slot i (lowest such i) with c_excp_i or c_need_jump_i.
  - Next cycle: redirect_valid_o=1 for exactly one cycle.
  - redirect_pc_o = excp_entry_i if excp, else c_jump_target_i[i]; excp has priority over jump.
  - FSM enters DRAIN at the same edge.
REQ-023 DRAIN: flush_o=1; remaining = (rob_tail_i - head) mod 2^ROB_LEN.
  - c_retire_o retires min(2, remaining) entries regardless of c_rob_valid_i.
  - sb_commit_valid_o=0; no redirect is generated in DRAIN.
  - Purpose: restore rename state.
REQ-024 DRAIN exits to RUN at the edge where the retire count equals remaining; the following cycle has flush_o=0.
  - remaining=0 on DRAIN entry: exit after a single cycle with no retires.
REQ-025 RUN with c_rob_valid_i[0]=0: no retire, no store commit, head holds.
REQ-026 Full ROB (head==rob_tail_i with entries valid) is treated as RUN-normal.
  - In DRAIN, head==rob_tail_i always means empty, because dispatch is stalled.

Reset
REQ-027 Reset asserted: head=0, FSM=RUN, redirect_valid_o=0, redirect_pc_o=0, flush_o=0, c_retire_o=0, sb_commit_valid_o=0, asynchronously.
  - Reset mid-DRAIN aborts the drain with no further retires.
REQ-028 First edge after reset deassertion behaves as RUN with head=0.

Verification
REQ-029 Two valid ALU entries, head=3 -> c_retire_o=2'b11, head=5 next cycle, no redirect.
REQ-030 head=31 (ROB_LEN=5), both valid -> c_rrrid_o={0,31}; head=1 after retire.
REQ-031 Slot0 store, sb_commit_ready_i=0 for 2 cycles then 1 -> no retire for 2 cycles, then c_retire_o=2'b01 with a single store handshake.
  - c_retire_o[1] stays 0 even if slot1 is a second valid store.
REQ-032 Slot0 need_jump target 0x1c000100, slot1 valid, head=4, rob_tail_i=10 -> c_retire_o=2'b01.
  - Next cycle: redirect_valid_o=1, pc=0x1c000100, flush_o=1.
  - DRAIN retires 2,2,1 over 3 cycles; flush_o=0 afterwards; head=10.
REQ-033 Slot1 excp with excp_entry_i=0x1c008000, slot0 normal -> c_retire_o=2'b11; redirect pc=0x1c008000.
  - remaining=0 -> one DRAIN cycle, then RUN.
REQ-034 rst asserted during DRAIN -> all outputs 0 immediately; head=0 and RUN after release.
